// File: rtl/simd_sub_seq.sv
// simd_sub_seq: multi-cycle packed-SIMD subtractor, c = a - b per lane.
// One 8-bit slice is processed per cycle, and the borrow is chained between
// the slices of a lane. Lanes are 8, 16 or 32 bits wide, and the result
// either wraps or saturates as unsigned or as two's complement.
// Optional feature macro: SIMD_SUB_FLAGS_EN adds the per-slice sat_flags output.
module simd_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  width,
    input  logic        saturate,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef SIMD_SUB_FLAGS_EN
    output logic [3:0]  sat_flags,
`endif
    output logic [31:0] c
);

    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Index of the top (most significant) slice of the lane that holds slice k.
    function automatic logic [1:0] top_of(input logic [1:0] w, input logic [1:0] k);
        case (w)
            2'b00:   top_of = k;
            2'b01:   top_of = {k[1], 1'b1};
            default: top_of = 2'b11;
        endcase
    endfunction

    // Indicates whether slice k starts a lane. A slice that starts a lane
    // takes no borrow from the slice below it.
    function automatic logic is_low(input logic [1:0] w, input logic [1:0] k);
        case (w)
            2'b00:   is_low = 1'b1;
            2'b01:   is_low = ~k[0];
            default: is_low = (k == 2'b00);
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  w_q, w_d;
    logic        sat_q, sat_d, sgn_q, sgn_d;
    logic        borrow_q, borrow_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  ovf_q, ovf_d;
    logic [31:0] c_q, c_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
`ifdef SIMD_SUB_FLAGS_EN
    logic [3:0]  flags_q, flags_d, flags_s;
`endif

    logic [7:0]  sa_s, sb_s;
    logic        bin_s;
    logic [8:0]  diff_s;
    logic        ovf_slice_s;
    logic [31:0] res_next_s, sat_res_s;
    logic [3:0]  ovf_next_s;
    logic        lane_sat_s;

    // Slice arithmetic, lane saturation and FSM next-state/output logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        w_d         = w_q;
        sat_d       = sat_q;
        sgn_d       = sgn_q;
        borrow_d    = borrow_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef SIMD_SUB_FLAGS_EN
        flags_d     = flags_q;
        flags_s     = 4'b0000;
`endif
        lane_sat_s  = 1'b0;
        sat_res_s   = 32'h0000_0000;

        // Compute the current slice with 9-bit arithmetic. Bit 8 of the
        // result is the borrow out of the slice.
        sa_s   = a_q[{k_q, 3'b000} +: SLICE_W];
        sb_s   = b_q[{k_q, 3'b000} +: SLICE_W];
        bin_s  = is_low(w_q, k_q) ? 1'b0 : borrow_q;
        diff_s = {1'b0, sa_s} - {1'b0, sb_s} - {8'b0000_0000, bin_s};
        if (sgn_q) begin
            ovf_slice_s = (sa_s[7] != sb_s[7]) && (diff_s[7] != sa_s[7]);
        end else begin
            ovf_slice_s = diff_s[8];
        end

        res_next_s = res_q;
        res_next_s[{k_q, 3'b000} +: SLICE_W] = diff_s[7:0];
        ovf_next_s = ovf_q;
        ovf_next_s[k_q] = (top_of(w_q, k_q) == k_q) && ovf_slice_s;

        // Saturate whole lanes. Every slice checks the overflow flag that
        // was recorded at its lane's top slice.
        for (int i = 0; i < NUM_SLICES; i++) begin
            lane_sat_s = sat_q && ovf_next_s[top_of(w_q, 2'(i))];
            if (!lane_sat_s) begin
                sat_res_s[i*SLICE_W +: SLICE_W] = res_next_s[i*SLICE_W +: SLICE_W];
            end else if (!sgn_q) begin
                sat_res_s[i*SLICE_W +: SLICE_W] = 8'h00;
            end else if (!a_q[{top_of(w_q, 2'(i)), 3'b111}]) begin
                sat_res_s[i*SLICE_W +: SLICE_W] = (top_of(w_q, 2'(i)) == 2'(i)) ? 8'h7F : 8'hFF;
            end else begin
                sat_res_s[i*SLICE_W +: SLICE_W] = (top_of(w_q, 2'(i)) == 2'(i)) ? 8'h80 : 8'h00;
            end
`ifdef SIMD_SUB_FLAGS_EN
            flags_s[i] = lane_sat_s;
`endif
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    w_d        = (width == 2'b11) ? 2'b10 : width;
                    sat_d      = saturate;
                    sgn_d      = is_signed;
                    k_d        = 2'b00;
                    borrow_d   = 1'b0;
                    ovf_d      = 4'b0000;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            BUSY: begin
                res_d    = res_next_s;
                ovf_d    = ovf_next_s;
                borrow_d = diff_s[8];
                k_d      = k_q + 2'b01;
                if (k_q == 2'b11) begin
                    c_d         = sat_res_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SIMD_SUB_FLAGS_EN
                    flags_d     = flags_s;
`endif
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers. The reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 2'b00;
            a_q         <= 32'h0000_0000;
            b_q         <= 32'h0000_0000;
            w_q         <= 2'b00;
            sat_q       <= 1'b0;
            sgn_q       <= 1'b0;
            borrow_q    <= 1'b0;
            res_q       <= 32'h0000_0000;
            ovf_q       <= 4'b0000;
            c_q         <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef SIMD_SUB_FLAGS_EN
            flags_q     <= 4'b0000;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            w_q         <= w_d;
            sat_q       <= sat_d;
            sgn_q       <= sgn_d;
            borrow_q    <= borrow_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef SIMD_SUB_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
`ifdef SIMD_SUB_FLAGS_EN
    assign sat_flags = flags_q;
`endif

endmodule

// File: tb/tb_simd_sub_seq.sv
// Self-checking bench for simd_sub_seq. It runs a table of directed vectors,
// hand-written backpressure and reset sequences, and random operations that
// are checked against a lane-level arithmetic model.
module tb_simd_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, saturate, is_signed, out_valid, out_ready;
    logic [31:0] a, b, c;
    logic [1:0]  width;
`ifdef SIMD_SUB_FLAGS_EN
    logic [3:0]  sat_flags;
`endif

    int errors = 0;
    int checks = 0;

    simd_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .width     (width),
        .saturate  (saturate),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SIMD_SUB_FLAGS_EN
        .sat_flags (sat_flags),
`endif
        .c         (c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [1:0]  vw;
        logic        vs;
        logic        vg;
        logic [31:0] ec;
        logic [3:0]  ef;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Lane-level reference model. It returns {flags, c}.
    function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [1:0] mw, input logic ms, input logic mg);
        int L;
        longint unsigned mask, la, lb, r;
        longint sa_v, sb_v, d, mx, mn;
        logic [31:0] rc;
        logic [3:0] rf;
        logic ov;
        L    = (mw == 2'b00) ? 8 : (mw == 2'b01) ? 16 : 32;
        mask = (64'd1 << L) - 64'd1;
        mx   = (64'sd1 <<< (L - 1)) - 64'sd1;
        mn   = -mx - 64'sd1;
        rc   = 32'h0;
        rf   = 4'h0;
        for (int j = 0; j < 32 / L; j++) begin
            la = ({32'h0, ma} >> (j * L)) & mask;
            lb = ({32'h0, mb} >> (j * L)) & mask;
            sa_v = longint'(la);
            sb_v = longint'(lb);
            if (((la >> (L - 1)) & 64'd1) != 64'd0) sa_v = sa_v - longint'(mask) - 64'sd1;
            if (((lb >> (L - 1)) & 64'd1) != 64'd0) sb_v = sb_v - longint'(mask) - 64'sd1;
            d  = sa_v - sb_v;
            ov = mg ? ((d > mx) || (d < mn)) : (la < lb);
            r  = (la - lb) & mask;
            if (ov && ms) begin
                if (!mg) r = 64'd0;
                else if (d > mx) r = longint'(mx) & mask;
                else r = longint'(mn) & mask;
            end
            rc = rc | 32'(r << (j * L));
            for (int s = 0; s < L / 8; s++) rf[j * (L / 8) + s] = ov && ms;
        end
        return {rf, rc};
    endfunction

    // Runs one full operation. It checks the handshake, the latency and the result.
    task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [1:0] tw, input logic ts, input logic tg,
                          input logic [31:0] ec, input logic [3:0] ef);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({nm, " in_ready before op"}, {31'b0, in_ready}, 32'd1);
        a = ta; b = tb_v; width = tw; saturate = ts; is_signed = tg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; width = 2'($urandom_range(0, 3));
        saturate = 1'($urandom); is_signed = 1'($urandom);
        chk({nm, " in_ready busy"}, {31'b0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({nm, " latency"}, n, 32'd4);
        chk({nm, " c"}, c, ec);
`ifdef SIMD_SUB_FLAGS_EN
        chk({nm, " sat_flags"}, {28'b0, sat_flags}, {28'b0, ef});
`else
        if (ef === 4'hx) chk({nm, " flags"}, 32'd0, 32'd1);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
        chk({nm, " in_ready back"}, {31'b0, in_ready}, 32'd1);
    endtask

    vec_t vecs[9];
    logic [35:0] m;
    logic [31:0] ra, rb;
    logic [1:0]  rw;
    logic        rs, rg;
    int          n;

    initial begin
        vecs[0] = '{32'h01020304, 32'h01010101, 2'b00, 1'b0, 1'b0, 32'h00010203, 4'b0000};
        vecs[1] = '{32'h807F0010, 32'h01FF0120, 2'b00, 1'b1, 1'b1, 32'h807FFFF0, 4'b1100};
        vecs[2] = '{32'h00050010, 32'h00060001, 2'b01, 1'b1, 1'b0, 32'h0000000F, 4'b1100};
        vecs[3] = '{32'h00000000, 32'h00000001, 2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b0000};
        vecs[4] = '{32'h00000000, 32'h00000001, 2'b11, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b0000};
        vecs[5] = '{32'h00000000, 32'h00000001, 2'b10, 1'b1, 1'b0, 32'h00000000, 4'b1111};
        vecs[6] = '{32'h80000000, 32'h00000001, 2'b10, 1'b1, 1'b1, 32'h80000000, 4'b1111};
        vecs[7] = '{32'h7FFF0000, 32'h80000001, 2'b01, 1'b1, 1'b1, 32'h7FFFFFFF, 4'b1100};
        vecs[8] = '{32'h00FF1080, 32'h01FE2080, 2'b00, 1'b1, 1'b0, 32'h00010000, 4'b1010};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; width = 2'b00; saturate = 1'b0; is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset c", c, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
`ifdef SIMD_SUB_FLAGS_EN
        chk("reset sat_flags", {28'b0, sat_flags}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vw,
                   vecs[i].vs, vecs[i].vg, vecs[i].ec, vecs[i].ef);
        end

        // Backpressure: hold DONE for 5 cycles while a new operand is offered.
        a = 32'h01020304; b = 32'h01010101; width = 2'b00; saturate = 1'b0; is_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp latency", n, 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            chk("bp c stable", c, 32'h00010203);
            chk("bp out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp idle stays", {31'b0, in_ready}, 32'd1);

        // Reset during BUSY while slice 2 is being processed.
        a = 32'h12345678; b = 32'h11111111; width = 2'b10; saturate = 1'b0; is_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst c", c, 32'd0);
        chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
        run_op("after reset", 32'h12345678, 32'h11111111, 2'b10, 1'b0, 1'b0,
               32'h01234567, 4'b0000);

        // Random operations checked against the lane model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rw = 2'($urandom_range(0, 3));
            rs = 1'($urandom); rg = 1'($urandom);
            m = model(ra, rb, rw, rs, rg);
            run_op($sformatf("rand%0d", i), ra, rb, rw, rs, rg, m[31:0], m[35:32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_sub_seq.md
Name: simd_sub_seq

Overview:
- Multi-cycle packed-SIMD subtractor; inverse operation of the packed saturating adder: c = a - b per lane.
- Processes one 8-bit slice per cycle, chaining borrow across slices inside a lane; lane width is 8, 16 or 32 bits.
- Optional signed or unsigned saturation.
- Sits beside the packed adder in the datapath; valid/ready on both sides.

Parameters:
- SLICE_W, 8, bits per slice; fixed, not overridable.
- NUM_SLICES, 4, slices per 32-bit word; fixed, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a  in  32  minuend, packed lanes.
- b  in  32  subtrahend, packed lanes.
- width  in  2  lane width: 00=8b, 01=16b, 10=32b, 11=reserved (treated as 32b).
- saturate  in  1  1=clamp on overflow, 0=wrap.
- is_signed  in  1  1=two's-complement lanes, 0=unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accept.
- c  out  32  packed result.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, slice index=0; out_valid=0, c=0, in_ready=1 on the following cycle.
  - Any in-flight operation is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a, b, width (11 mapped to 10), saturate, is_signed; slice index=0; go to BUSY.
- BUSY:
  - Each cycle, slice k result = a[k] - b[k] - borrow_in. This is 9-bit arithmetic; bit 8 is borrow_out.
  - borrow_in = 0 when slice k is the lowest slice of its lane (8b: every k; 16b: k=0,2; 32b: k=0); otherwise it is the registered borrow_out of slice k-1.
  - At each lane's top slice, record the lane overflow flag:
    - Unsigned: overflow = borrow_out.
    - Signed: overflow = (sign_a != sign_b) && (sign_result != sign_a), using the lane MSBs.
  - After slice 3 is processed, go to DONE.
- Saturation is applied to whole lanes on the BUSY->DONE transition, and only when saturate=1 and the lane overflow flag is set:
  - Unsigned: lane = all zeros.
  - Signed, sign_a=0: lane = 0x7F / 0x7FFF / 0x7FFFFFFF.
  - Signed, sign_a=1: lane = 0x80 / 0x8000 / 0x80000000.
  - saturate=0: raw wrapped result.
- DONE:
  - out_valid=1; c is stable and held until out_ready=1.
  - On out_ready=1: out_valid falls on the next cycle and state returns to IDLE.
  - No new operand is accepted in the same cycle.
- Latency: operand accepted at edge T; out_valid=1 from edge T+4. Minimum initiation interval 6 cycles.
- Boundary rules:
  - in_valid while BUSY/DONE is ignored (in_ready=0); the producer holds its operands.
  - Input changes after capture have no effect.
  - Reset asserted in any state overrides every other input.
  - width=11 gives results identical to width=10.

Optional Feature:
- Macro: SIMD_SUB_FLAGS_EN.
- Defined: extra output port sat_flags[3:0], one bit per slice.
  - A bit is set for every slice of a lane that saturated.
  - Valid with out_valid; reset value 0.
  - Bits are set only when saturate=1.
- Undefined: port absent; lane behaviour unchanged.

Test Plan:
- 8b unsigned wrap: a=0x01020304, b=0x01010101, saturate=0 -> c=0x00010203; out_valid at T+4.
- 8b signed saturate: a=0x807F0010, b=0x01FF0120 -> c=0x807FFFF0 (lane3 clamps 0x80, lane2 clamps 0x7F); sat_flags=1100 if enabled.
- 16b unsigned saturate: a=0x00050010, b=0x00060001 -> c=0x0000000F (upper lane clamps to 0).
- 32b wrap, full borrow chain: a=0x00000000, b=0x00000001 -> c=0xFFFFFFFF; width=11 gives the same result.
- Backpressure: out_ready=0 for 5 cycles in DONE -> c, out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-BUSY at slice 2 -> next cycle out_valid=0, c=0, in_ready=1; a new operation completes correctly.
